// File: rtl/ref_mem_pkg.sv
// Shared types and helpers for the reference-memory lane rotator.
// Lane indices are plain ints so the helpers can be used in elaboration-time
// localparams, where each stage works out its fixed lane wiring.
package ref_mem_pkg;

    localparam int NUM_MEM_DEF = 8;
    localparam int MEM_W_DEF   = 256;

    typedef enum logic {
        DIR_FWD = 1'b0,   // out lane j takes in lane j+s (legacy direction)
        DIR_REV = 1'b1    // out lane j takes in lane j-s
    } dir_e;

    typedef enum logic {
        MODE_ROT   = 1'b0, // circular rotate
        MODE_SHIFT = 1'b1  // shift, vacated lanes become zero
    } mode_e;

    // Unwrapped source lane for output lane j when moving by step lanes.
    // The result can fall outside [0, n).
    function automatic int lane_src(input int j, input int step, input dir_e dir);
        return (dir == DIR_FWD) ? j + step : j - step;
    endfunction

    // True when a source lane index points at a real lane.
    function automatic bit lane_in_range(input int idx, input int n);
        return (idx >= 0) && (idx < n);
    endfunction

    // Circular wrap of a lane index; n is a power of two, so masking
    // handles negative indices as well.
    function automatic int lane_wrap(input int idx, input int n);
        return idx & (n - 1);
    endfunction

endpackage

// File: rtl/ref_rot_stage.sv
// One pipeline stage of the lane rotator: moves all lanes by STEP when the
// matching bit of the lane offset is set, then registers the result together
// with valid and the control fields needed by later stages.
module ref_rot_stage
    import ref_mem_pkg::*;
#(
    parameter  int NUM_MEM = NUM_MEM_DEF,
    parameter  int MEM_W   = MEM_W_DEF,
    parameter  int STEP    = 1,
    localparam int SHIFT_W = $clog2(NUM_MEM),
    localparam int DATA_W  = NUM_MEM * MEM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  dir_e               in_dir,
    input  mode_e              in_mode,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [SHIFT_W-1:0] out_shift,
    output dir_e               out_dir,
    output mode_e              out_mode
);

    // Offset bit that this stage is responsible for.
    localparam int BIT = $clog2(STEP);

    logic [DATA_W-1:0] moved;

    for (genvar j = 0; j < NUM_MEM; j++) begin : g_lane
        localparam int SRC_F  = lane_src(j, STEP, DIR_FWD);
        localparam int SRC_R  = lane_src(j, STEP, DIR_REV);
        localparam int WRAP_F = lane_wrap(SRC_F, NUM_MEM);
        localparam int WRAP_R = lane_wrap(SRC_R, NUM_MEM);
        localparam bit FILL_F = !lane_in_range(SRC_F, NUM_MEM);
        localparam bit FILL_R = !lane_in_range(SRC_R, NUM_MEM);

        logic [MEM_W-1:0] lane_fwd;
        logic [MEM_W-1:0] lane_rev;

        // A lane whose source falls off the end wraps in rotate mode and is
        // zero in shift mode; all lane selects are fixed wiring.
        assign lane_fwd = (in_mode == MODE_SHIFT && FILL_F) ? '0
                                                            : in_data[WRAP_F*MEM_W +: MEM_W];
        assign lane_rev = (in_mode == MODE_SHIFT && FILL_R) ? '0
                                                            : in_data[WRAP_R*MEM_W +: MEM_W];

        assign moved[j*MEM_W +: MEM_W] = !in_shift[BIT]        ? in_data[j*MEM_W +: MEM_W] :
                                         (in_dir == DIR_REV)   ? lane_rev
                                                               : lane_fwd;
    end

    // Stage register: loads from the previous stage when the pipeline advances,
    // otherwise holds so a stalled beat stays intact.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here uses <= so all stages sample their
        // predecessor's old value on the same edge, independent of statement order.
        if (!rst_n) begin
            out_valid <= 1'b0;
            // NOTE: data is cleared too, so out_data reads zero straight out of
            // reset rather than whatever a discarded beat left behind.
            out_data  <= '0;
            out_shift <= '0;
            out_dir   <= DIR_FWD;
            out_mode  <= MODE_ROT;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= moved;
            out_shift <= in_shift;
            out_dir   <= in_dir;
            out_mode  <= in_mode;
        end
    end

endmodule

// File: rtl/ref_mem_rotator.sv
// Pipelined lane rotator/shifter between the reference-memory read ports and
// the search-window PE array. Stage k moves lanes by 2^k, so SHIFT_W stages
// cover any offset 0..NUM_MEM-1 with a fixed latency of SHIFT_W cycles.
module ref_mem_rotator
    import ref_mem_pkg::*;
#(
    parameter  int NUM_MEM = NUM_MEM_DEF,
    parameter  int MEM_W   = MEM_W_DEF,
    localparam int SHIFT_W = $clog2(NUM_MEM),
    localparam int DATA_W  = NUM_MEM * MEM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_dir,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data
);

    // Index 0 is the input port, index k+1 is the output of stage k.
    logic               v_q  [0:SHIFT_W];
    logic [DATA_W-1:0]  d_q  [0:SHIFT_W];
    logic [SHIFT_W-1:0] sh_q [0:SHIFT_W];
    dir_e               dr_q [0:SHIFT_W];
    mode_e              md_q [0:SHIFT_W];

    logic en;

    // The whole pipeline moves together: it may advance whenever the output
    // slot is empty or being taken this cycle. Bubbles advance with it.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign v_q[0]  = in_valid;
    assign d_q[0]  = in_data;
    assign sh_q[0] = in_shift;
    assign dr_q[0] = dir_e'(in_dir);
    assign md_q[0] = mode_e'(in_mode);

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        ref_rot_stage #(
            .NUM_MEM (NUM_MEM),
            .MEM_W   (MEM_W),
            .STEP    (1 << k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (v_q[k]),
            .in_data   (d_q[k]),
            .in_shift  (sh_q[k]),
            .in_dir    (dr_q[k]),
            .in_mode   (md_q[k]),
            .out_valid (v_q[k+1]),
            .out_data  (d_q[k+1]),
            .out_shift (sh_q[k+1]),
            .out_dir   (dr_q[k+1]),
            .out_mode  (md_q[k+1])
        );
    end

    assign out_valid = v_q[SHIFT_W];
    assign out_data  = d_q[SHIFT_W];

    // Control fields leaving the last stage have no further consumer.
    logic unused_tail;
    assign unused_tail = ^{sh_q[SHIFT_W], dr_q[SHIFT_W], md_q[SHIFT_W]};

endmodule

// File: tb/tb_ref_mem_rotator.sv
// Directed bench for ref_mem_rotator at 8x256, plus random sweeps at 4x32
// and 16x64, all checked against a lane-index reference model.
module tb_ref_mem_rotator;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    // 8 x 256 instance
    logic          m8_in_valid, m8_in_ready, m8_out_valid, m8_out_ready;
    logic [2047:0] m8_in_data, m8_out_data;
    logic [2:0]    m8_in_shift;
    logic          m8_in_dir, m8_in_mode;

    // 4 x 32 instance
    logic          m4_in_valid, m4_in_ready, m4_out_valid, m4_out_ready;
    logic [127:0]  m4_in_data, m4_out_data;
    logic [1:0]    m4_in_shift;
    logic          m4_in_dir, m4_in_mode;

    // 16 x 64 instance
    logic          m16_in_valid, m16_in_ready, m16_out_valid, m16_out_ready;
    logic [1023:0] m16_in_data, m16_out_data;
    logic [3:0]    m16_in_shift;
    logic          m16_in_dir, m16_in_mode;

    ref_mem_rotator #(.NUM_MEM(8), .MEM_W(256)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m8_in_valid), .in_ready(m8_in_ready), .in_data(m8_in_data),
        .in_shift(m8_in_shift), .in_dir(m8_in_dir), .in_mode(m8_in_mode),
        .out_valid(m8_out_valid), .out_ready(m8_out_ready), .out_data(m8_out_data)
    );

    ref_mem_rotator #(.NUM_MEM(4), .MEM_W(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m4_in_valid), .in_ready(m4_in_ready), .in_data(m4_in_data),
        .in_shift(m4_in_shift), .in_dir(m4_in_dir), .in_mode(m4_in_mode),
        .out_valid(m4_out_valid), .out_ready(m4_out_ready), .out_data(m4_out_data)
    );

    ref_mem_rotator #(.NUM_MEM(16), .MEM_W(64)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m16_in_valid), .in_ready(m16_in_ready), .in_data(m16_in_data),
        .in_shift(m16_in_shift), .in_dir(m16_in_dir), .in_mode(m16_in_mode),
        .out_valid(m16_out_valid), .out_ready(m16_out_ready), .out_data(m16_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: source lane for output lane j, or -1 for a zero lane.
    function automatic int ref_src(input int j, input int s, input bit dir,
                                   input bit mode, input int n);
        int idx;
        idx = dir ? j - s : j + s;
        if (idx >= 0 && idx < n) return idx;
        if (mode) return -1;
        return dir ? idx + n : idx - n;
    endfunction

    function automatic logic [255:0] lane_of(input logic [2047:0] v, input int i, input int w);
        logic [255:0] r;
        r = '0;
        for (int b = 0; b < w; b++) r[b] = v[i*w + b];
        return r;
    endfunction

    task automatic check_beat(input string tag, input logic [2047:0] din,
                              input logic [2047:0] dout, input int n, input int w,
                              input int s, input bit dir, input bit mode);
        int src;
        for (int j = 0; j < n; j++) begin
            src = ref_src(j, s, dir, mode, n);
            check($sformatf("%s s=%0d d=%0d m=%0d lane%0d", tag, s, dir, mode, j),
                  lane_of(dout, j, w), (src < 0) ? 256'd0 : lane_of(din, src, w));
        end
    endtask

    // Compare the 8-lane output against a hand-written table of lane bytes.
    task automatic check_bytes8(input string tag, input logic [7:0] exp [8]);
        for (int j = 0; j < 8; j++)
            check($sformatf("%s lane%0d", tag, j), lane_of(m8_out_data, j, 256),
                  256'({32{exp[j]}}));
    endtask

    function automatic logic [2047:0] pat8();
        logic [2047:0] d;
        for (int i = 0; i < 8; i++) d[i*256 +: 256] = {32{8'(8'h10 + i)}};
        return d;
    endfunction

    // Present one beat on the 8-lane instance and wait for it at the output.
    task automatic send8(input logic [2047:0] data, input int s, input bit dir,
                         input bit mode, output int lat);
        @(negedge clk);
        m8_in_valid  = 1'b1;
        m8_in_data   = data;
        m8_in_shift  = 3'(s);
        m8_in_dir    = dir;
        m8_in_mode   = mode;
        m8_out_ready = 1'b1;
        #1;
        check("send8 in_ready", 256'(m8_in_ready), 256'd1);
        @(negedge clk);
        m8_in_valid = 1'b0;
        lat = 1;
        while (!m8_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic sweep4(input int count);
        int s, lat; bit dir, mode; logic [127:0] d;
        for (int t = 0; t < count; t++) begin
            for (int k = 0; k < 4; k++) d[k*32 +: 32] = $urandom;
            s = $urandom_range(0, 3); dir = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            m4_in_valid = 1'b1; m4_in_data = d; m4_in_shift = 2'(s);
            m4_in_dir = dir; m4_in_mode = mode; m4_out_ready = 1'b1;
            #1;
            check("n4 in_ready", 256'(m4_in_ready), 256'd1);
            @(negedge clk);
            m4_in_valid = 1'b0;
            lat = 1;
            while (!m4_out_valid && lat < 20) begin @(negedge clk); lat++; end
            check("n4 latency", 256'(lat), 256'd2);
            check_beat("n4", 2048'(d), 2048'(m4_out_data), 4, 32, s, dir, mode);
        end
    endtask

    task automatic sweep16(input int count);
        int s, lat; bit dir, mode; logic [1023:0] d;
        for (int t = 0; t < count; t++) begin
            for (int k = 0; k < 32; k++) d[k*32 +: 32] = $urandom;
            s = (t == 0) ? 0 : $urandom_range(0, 15);
            dir = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            m16_in_valid = 1'b1; m16_in_data = d; m16_in_shift = 4'(s);
            m16_in_dir = dir; m16_in_mode = mode; m16_out_ready = 1'b1;
            #1;
            check("n16 in_ready", 256'(m16_in_ready), 256'd1);
            @(negedge clk);
            m16_in_valid = 1'b0;
            lat = 1;
            while (!m16_out_valid && lat < 20) begin @(negedge clk); lat++; end
            check("n16 latency", 256'(lat), 256'd4);
            check_beat("n16", 2048'(d), 2048'(m16_out_data), 16, 64, s, dir, mode);
        end
    endtask

    // Backpressure stream: 8 beats, s = 0..7, random out_ready.
    task automatic stream8();
        int idx = 0, got = 0, s_exp;
        logic [2047:0] q_d [$];
        int            q_s [$];
        logic [2047:0] held, d, d_exp;
        bit            was_held = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            @(negedge clk);
            if (was_held) begin
                check("hold valid", 256'(m8_out_valid), 256'd1);
                check("hold data", 256'(m8_out_data == held), 256'd1);
            end
            m8_out_ready = 1'($urandom_range(0, 1));
            m8_in_valid  = (idx < 8);
            if (idx < 8) begin
                for (int i = 0; i < 8; i++) d[i*256 +: 256] = {{31{8'(8'h10 + i)}}, 8'(idx)};
                m8_in_data  = d;
                m8_in_shift = 3'(idx);
                m8_in_dir   = 1'(idx & 1);
                m8_in_mode  = 1'((idx >> 1) & 1);
            end
            #1;
            check("stream in_ready", 256'(m8_in_ready), 256'(!(m8_out_valid && !m8_out_ready)));
            if (m8_out_valid && m8_out_ready) begin
                check("stream extra beat", 256'(q_d.size() != 0), 256'd1);
                if (q_d.size() != 0) begin
                    d_exp = q_d.pop_front();
                    s_exp = q_s.pop_front();
                    check_beat("stream", d_exp, m8_out_data, 8, 256, s_exp,
                               1'(s_exp & 1), 1'((s_exp >> 1) & 1));
                    got++;
                end
            end
            was_held = m8_out_valid && !m8_out_ready;
            held     = m8_out_data;
            if (m8_in_valid && m8_in_ready) begin
                q_d.push_back(m8_in_data);
                q_s.push_back(idx);
                idx++;
            end
        end
        check("stream beats out", 256'(got), 256'd8);
        m8_in_valid  = 1'b0;
        m8_out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("stream drained", 256'(m8_out_valid), 256'd0);
    endtask

    initial begin
        logic [7:0] tbl [8];
        int lat;
        bit any_out;

        rst_n = 1'b0;
        m8_in_valid = 0;  m8_in_data = '0;  m8_in_shift = '0;  m8_in_dir = 0;  m8_in_mode = 0;  m8_out_ready = 1;
        m4_in_valid = 0;  m4_in_data = '0;  m4_in_shift = '0;  m4_in_dir = 0;  m4_in_mode = 0;  m4_out_ready = 1;
        m16_in_valid = 0; m16_in_data = '0; m16_in_shift = '0; m16_in_dir = 0; m16_in_mode = 0; m16_out_ready = 1;

        repeat (2) @(negedge clk);
        check("reset out_valid", 256'(m8_out_valid), 256'd0);
        check("reset out_data", 256'(|m8_out_data), 256'd0);
        check("reset in_ready", 256'(m8_in_ready), 256'd1);
        rst_n = 1'b1;

        // Rotate forward s=3, with latency.
        send8(pat8(), 3, 1'b0, 1'b0, lat);
        check("rot fwd latency", 256'(lat), 256'd3);
        tbl = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h10, 8'h11, 8'h12};
        check_bytes8("rot fwd s3", tbl);

        send8(pat8(), 3, 1'b1, 1'b0, lat);
        check("rot rev latency", 256'(lat), 256'd3);
        tbl = '{8'h15, 8'h16, 8'h17, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        check_bytes8("rot rev s3", tbl);

        send8(pat8(), 5, 1'b0, 1'b1, lat);
        tbl = '{8'h15, 8'h16, 8'h17, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes8("shift fwd s5", tbl);

        send8(pat8(), 5, 1'b1, 1'b1, lat);
        tbl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12};
        check_bytes8("shift rev s5", tbl);

        // s=0 is identity in every mode, with unchanged latency.
        tbl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        for (int c = 0; c < 4; c++) begin
            send8(pat8(), 0, 1'(c & 1), 1'(c >> 1), lat);
            check("s0 latency", 256'(lat), 256'd3);
            check_bytes8($sformatf("s0 combo%0d", c), tbl);
        end

        stream8();

        // Fill the pipeline under backpressure, then reset mid-stall.
        m8_out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            m8_in_valid = 1'b1; m8_in_data = pat8(); m8_in_shift = 3'(b);
            m8_in_dir = 1'b0; m8_in_mode = 1'b0;
            #1;
            check("fill in_ready", 256'(m8_in_ready), 256'd1);
        end
        @(negedge clk);
        #1;
        check("full out_valid", 256'(m8_out_valid), 256'd1);
        check("full in_ready", 256'(m8_in_ready), 256'd0);
        @(negedge clk);
        #1;
        check("full held in_ready", 256'(m8_in_ready), 256'd0);
        rst_n = 1'b0;
        m8_in_valid = 1'b0;
        #1;
        check("midrst out_valid", 256'(m8_out_valid), 256'd0);
        check("midrst out_data", 256'(|m8_out_data), 256'd0);
        check("midrst in_ready", 256'(m8_in_ready), 256'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m8_out_ready = 1'b1;
        any_out = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_out |= m8_out_valid;
        end
        check("post-rst no output", 256'(any_out), 256'd0);

        send8(pat8(), 1, 1'b0, 1'b0, lat);
        check("post-rst latency", 256'(lat), 256'd3);
        tbl = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h10};
        check_bytes8("post-rst rot s1", tbl);

        sweep4(10);
        sweep16(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
